sd_spi_response_tx: RTL

//  SD-card SPI-mode response transmitter; the MISO-side counterpart of the command-frame receiver.

---
 rtl/sd_spi_response_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_response_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sd_spi_response_tx                                           |
// | Description : SD SPI-mode response transmitter (NCR filler, R1..R7, busy)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sd_spi_response_tx #(
  parameter int NCR_BYTES = 1,
  parameter int MAX_BYTES = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_SPI_CLK,
  input  logic                   io_SPI_CS,
  output logic                   io_SPI_DO,
  input  logic                   io_Start,
  input  logic [2:0]             io_ResponseLength,
  input  logic [8*MAX_BYTES-1:0] io_ResponseData,
  input  logic                   io_Busy,
  output logic                   io_Ready,
  output logic                   io_Done,
  output logic [1:0]             io____state
);

  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int CNT_W  = (MAX_BYTES > 8) ? $clog2(MAX_BYTES) : 3;
  localparam logic [CNT_W-1:0] c_ncr_last = CNT_W'(NCR_BYTES - 1);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NCR  = 2'd1,
    S_RESP = 2'd2,
    S_BUSY = 2'd3
  } state_t;

  // Reset asserts asynchronously and releases on a clock edge.
  logic r_rst_meta;
  logic r_rst_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  state_t            r_state, w_state_d;
  logic              r_spi_clk_q;
  logic [6:0]        r_shift, w_shift_d;     // bits still to follow the one on DO
  logic [2:0]        r_bit_cnt, w_bit_cnt_d;
  logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_d;
  logic [DATA_W-1:0] r_data, w_data_d;
  logic [CNT_W-1:0]  r_last_idx, w_last_d;
  logic              r_do, w_do_d;
  logic              r_done, w_done_d;

  logic              w_fall;
  logic [CNT_W-1:0]  w_next_idx;
  logic [7:0]        w_next_byte;
  logic [7:0]        w_first_byte;
  logic [CNT_W-1:0]  w_last_idx;

  assign w_fall       = r_spi_clk_q & ~io_SPI_CLK;
  assign w_next_idx   = r_byte_cnt + c_one;
  assign w_next_byte  = r_data[DATA_W-1-8*int'(w_next_idx) -: 8];
  assign w_first_byte = r_data[DATA_W-1 -: 8];

  // Length 0 behaves as 1; lengths beyond the buffer are clamped.
  always_comb begin
    w_last_idx = '0;
    if (io_ResponseLength == 3'd0)
      w_last_idx = '0;
    else if (int'(io_ResponseLength) > MAX_BYTES)
      w_last_idx = CNT_W'(MAX_BYTES - 1);
    else
      w_last_idx = CNT_W'(io_ResponseLength - 3'd1);
  end

  always_ff @(posedge clock or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state     <= S_IDLE;
      r_spi_clk_q <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_data      <= '0;
      r_last_idx  <= '0;
      r_do        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_spi_clk_q <= io_SPI_CLK;
      r_shift     <= w_shift_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_byte_cnt  <= w_byte_cnt_d;
      r_data      <= w_data_d;
      r_last_idx  <= w_last_d;
      r_do        <= w_do_d;
      r_done      <= w_done_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_shift_d    = r_shift;
    w_bit_cnt_d  = r_bit_cnt;
    w_byte_cnt_d = r_byte_cnt;
    w_data_d     = r_data;
    w_last_d     = r_last_idx;
    w_do_d       = r_do;
    w_done_d     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_do_d = 1'b1;
        // A fall coinciding with an accepted Start is deliberately not counted.
        if (io_Start && !io_SPI_CS) begin
          w_data_d     = io_ResponseData;
          w_last_d     = w_last_idx;
          w_shift_d    = 7'h7F;
          w_bit_cnt_d  = 3'd7;
          w_byte_cnt_d = c_ncr_last;
          w_state_d    = S_NCR;
        end
      end
      default: begin
        if (io_SPI_CS) begin
          w_state_d = S_IDLE;
          w_do_d    = 1'b1;
        end else if (w_fall) begin
          if (r_bit_cnt != 3'd0) begin
            w_do_d      = r_shift[6];
            w_shift_d   = {r_shift[5:0], 1'b0};
            w_bit_cnt_d = r_bit_cnt - 3'd1;
          end else begin
            w_bit_cnt_d = 3'd7;
            case (r_state)
              S_NCR: begin
                if (r_byte_cnt != '0) begin
                  w_do_d       = 1'b1;
                  w_shift_d    = 7'h7F;
                  w_byte_cnt_d = r_byte_cnt - c_one;
                end else begin
                  w_state_d    = S_RESP;
                  w_do_d       = w_first_byte[7];
                  w_shift_d    = w_first_byte[6:0];
                  w_byte_cnt_d = '0;
                end
              end
              S_RESP: begin
                if (r_byte_cnt != r_last_idx) begin
                  w_do_d       = w_next_byte[7];
                  w_shift_d    = w_next_byte[6:0];
                  w_byte_cnt_d = w_next_idx;
                end else if (io_Busy) begin
                  w_state_d = S_BUSY;
                  w_do_d    = 1'b0;
                  w_shift_d = 7'h00;
                end else begin
                  w_state_d = S_IDLE;
                  w_do_d    = 1'b1;
                  w_done_d  = 1'b1;
                end
              end
              default: begin
                if (io_Busy) begin
                  w_do_d    = 1'b0;
                  w_shift_d = 7'h00;
                end else begin
                  w_state_d = S_IDLE;
                  w_do_d    = 1'b1;
                  w_done_d  = 1'b1;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  assign io_SPI_DO   = r_do;
  assign io_Ready    = (r_state == S_IDLE);
  assign io_Done     = r_done;
  assign io____state = r_state;

endmodule
`default_nettype wire
